clock_divider_param: RTL and testbench
======================================

# clock_divider_param

Parametrised, runtime-programmable clock/enable divider; successor to the fixed 11-bit MSB divider used for the motor-driver enable pulse generator. Divides the 50 MHz system clock by a programmable integer N ≥ 2. Produces an approx.-50 % square output plus a single-cycle tick strobe per period. Divisor changes are double-buffered and take effect only at a period boundary, so downstream enable/PWM logic never sees a runt pulse.

## Interface
- WIDTH, 16: counter and divisor width in bits.
- DIV_DEFAULT, 2048: divisor after reset (50 MHz / 2048 ≈ 24.4 kHz, ≈ 41 µs period).
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  run enable; 0 stops and clears the divider.
- div_wr  in  1  single-cycle strobe: capture div_in into the shadow register.
- div_in  in  WIDTH  requested divisor N.
- sync  in  1  restart strobe; present only with CLKDIV_SYNC_EN.
- div_pend  out  1  shadow divisor written but not yet active.
- count  out  WIDTH  current counter value, 0..N_active−1.
- tick  out  1  one-cycle strobe, once per period.
- q  out  1  divided square output.

## Operation
- Registers: count, div_active, div_shadow, div_pend, tick, q. All outputs are direct flop outputs.
- Reset (rst=1): count=0, div_active=div_shadow=DIV_DEFAULT, div_pend=0, tick=0, q=0. Reset overrides every other input.
- Clamp: div_in values 0 and 1 are stored as 2. No other value is altered.
- Run (en=1): count increments each cycle and wraps from div_active−1 to 0 (wrap cycle).
- tick is registered high in the cycle where count becomes 0 by a wrap. Exactly one tick occurs per N cycles, and a tick is never produced by reset, en or sync.
- q is 1 iff count ≥ div_active − (div_active>>1). It is updated in the same edge as count. N=2048 gives 1024 low / 1024 high; N=5 gives 3 low / 2 high.
- Write (div_wr=1): div_shadow ← clamp(div_in) and div_pend ← 1. A second write before application overwrites the shadow; the last write wins.
- Apply: on a wrap edge with div_pend=1, div_active ← div_shadow and div_pend ← 0.
- Write and wrap in the same cycle: the wrap applies the old shadow if one was pending. The new value is captured and div_pend stays 1 until the next wrap.
- Stop (en=0): count ← 0, q ← 0, tick ← 0. A pending shadow is applied immediately in that edge. A div_wr while stopped takes effect on the following edge.
- Resuming en=1 starts a full period from count=0.

## Timing
- div_wr → div_pend=1: 1 cycle.
- Running: divisor takes effect at the next wrap, at most N_old cycles later.
- Stopped: divisor takes effect 1 cycle after the write.
- tick: high for 1 cycle, period exactly N_active cycles in steady state.
- en fall → count=0, q=0 on the next edge. en rise → first tick after N_active cycles.
- No combinational input-to-output path.

## Configuration
- CLKDIV_SYNC_EN defined: sync port exists. sync=1 with en=1 forces count ← 0 and q ← 0 with no tick, and applies any pending shadow as a wrap would. sync has priority over a coincident natural wrap, which then also emits no tick. sync is ignored while en=0.
- CLKDIV_SYNC_EN undefined: no sync port; the divider restarts only via rst or en.

## Structure
- Package clkdiv_pkg holds:
  - constant DIV_MIN = 2;
  - function clkdiv_clamp(value) returning max(value, DIV_MIN);
  - typedef enum for the next-count source: HOLD, INCR, WRAP, CLEAR.
- One sub-module is natural: clkdiv_shadow_reg, which owns div_in clamp, div_shadow, div_pend and the apply handshake. The top keeps the counter, q and tick.

## Test plan
- Reset, en=1, defaults → first tick 2048 cycles after en rise, then every 2048; q low 1024 / high 1024.
- div_wr div_in=5 mid-period of N=2048 → div_pend=1 until the wrap, then period 5, q pattern 0,0,0,1,1, tick every 5 cycles.
- div_wr div_in=0 then div_in=1 → clamped; N=2 yields alternating q and a tick every 2 cycles.
- div_wr in the exact wrap cycle while N=8 and shadow=4 pending → next period is 4, following period uses the new value, div_pend held high in between.
- en dropped at count=3 with shadow=10 pending → count=0, q=0 next edge, div_active=10; en high → first tick 10 cycles later.
- CLKDIV_SYNC_EN: sync pulsed at count=6 with N=8 → count=0 next edge, no tick, next tick 8 cycles later. rst asserted mid-period → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants, divisor clamp and next-count source encoding for the clock divider.
package clkdiv_pkg;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic [1:0] {
    HOLD,
    INCR,
    WRAP,
    CLEAR
  } cnt_src_e;

  // Divisors below DIV_MIN cannot form a period with both a low and a high phase.
  function automatic logic [31:0] clkdiv_clamp(input logic [31:0] value);
    return (value < 32'(DIV_MIN)) ? 32'(DIV_MIN) : value;
  endfunction

endpackage

// File: rtl/clkdiv_shadow_reg.sv
// Double-buffered divisor: captures clamped writes into a shadow and moves them
// to the active divisor only when the counter signals a period boundary.
module clkdiv_shadow_reg
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DIV_DEFAULT = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_in,
  input  logic             apply,
  output logic [WIDTH-1:0] div_active,
  output logic             div_pend
);

  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] div_shadow_q, div_shadow_d;
  logic             div_pend_q, div_pend_d;

  // A boundary consumes the shadow held before this edge; a coincident write re-arms it.
  always_comb begin
    div_active_d = div_active_q;
    div_shadow_d = div_shadow_q;
    div_pend_d   = div_pend_q;
    if (apply && div_pend_q) begin
      div_active_d = div_shadow_q;
      div_pend_d   = 1'b0;
    end
    if (div_wr) begin
      div_shadow_d = WIDTH'(clkdiv_clamp(32'(div_in)));
      div_pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_active_q <= WIDTH'(DIV_DEFAULT);
      div_shadow_q <= WIDTH'(DIV_DEFAULT);
      div_pend_q   <= 1'b0;
    end else begin
      div_active_q <= div_active_d;
      div_shadow_q <= div_shadow_d;
      div_pend_q   <= div_pend_d;
    end
  end

  assign div_active = div_active_q;
  assign div_pend   = div_pend_q;

endmodule

// File: rtl/clock_divider_param.sv
// Runtime-programmable integer clock/enable divider with square output and per-period tick.
// Optional restart input enabled by defining CLKDIV_SYNC_EN.
module clock_divider_param
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DIV_DEFAULT = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_in,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             div_pend,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             q
);

  logic [WIDTH-1:0] div_active;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             q_q, q_d;
  logic             sync_c;
  logic             last_c;
  logic             apply_c;
  cnt_src_e         src_c;

`ifdef CLKDIV_SYNC_EN
  assign sync_c = en & sync;
`else
  assign sync_c = 1'b0;
`endif

  clkdiv_shadow_reg #(
    .WIDTH      (WIDTH),
    .DIV_DEFAULT(DIV_DEFAULT)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .div_wr    (div_wr),
    .div_in    (div_in),
    .apply     (apply_c),
    .div_active(div_active),
    .div_pend  (div_pend)
  );

  // Stop and restart take priority over a natural wrap and never produce a tick.
  always_comb begin
    src_c   = HOLD;
    count_d = count_q;
    last_c  = (count_q >= (div_active - WIDTH'(1)));
    if (!en || sync_c) begin
      src_c = CLEAR;
    end else if (last_c) begin
      src_c = WRAP;
    end else begin
      src_c = INCR;
    end
    case (src_c)
      HOLD:        count_d = count_q;
      INCR:        count_d = count_q + WIDTH'(1);
      WRAP, CLEAR: count_d = '0;
      default:     count_d = count_q;
    endcase
    apply_c = (src_c == WRAP) || (src_c == CLEAR);
    tick_d  = (src_c == WRAP);
    // Threshold is at least 1, so a cleared count always drives q low.
    q_d     = (count_d >= (div_active - (div_active >> 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      q_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      q_q     <= q_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign q     = q_q;

endmodule

// File: tb/tb_clock_divider_param.sv
// Scoreboard bench for clock_divider_param; sync scenario built when CLKDIV_SYNC_EN is defined.
module tb_clock_divider_param;

  localparam int unsigned W   = 16;
  localparam int unsigned DEF = 2048;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         div_wr = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         sync = 1'b0;
  logic         div_pend;
  logic [W-1:0] count;
  logic         tick;
  logic         q;

  typedef struct {
    int unsigned cnt;
    bit          tk;
    bit          qq;
    bit          pend;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;

  int unsigned m_count, m_active, m_shadow;
  bit          m_pend, m_tick, m_q;

  always #5 clk = ~clk;

  clock_divider_param #(
    .WIDTH      (W),
    .DIV_DEFAULT(DEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_wr  (div_wr),
    .div_in  (div_in),
`ifdef CLKDIV_SYNC_EN
    .sync    (sync),
`endif
    .div_pend(div_pend),
    .count   (count),
    .tick    (tick),
    .q       (q)
  );

  // Drive one cycle of stimulus, push the expected post-edge state, return after the edge.
  task automatic step(input bit r, input bit e, input bit wr, input int unsigned din, input bit s);
    bit s_eff, wrap, restart;
    @(negedge clk);
    rst = r; en = e; div_wr = wr; div_in = W'(din); sync = s;
`ifdef CLKDIV_SYNC_EN
    s_eff = e && s;
`else
    s_eff = 1'b0;
`endif
    if (r) begin
      m_count = 0; m_active = DEF; m_shadow = DEF; m_pend = 0; m_tick = 0; m_q = 0;
    end else begin
      wrap    = e && !s_eff && (m_count == m_active - 1);
      restart = !e || s_eff || wrap;
      if (restart && m_pend) begin
        m_active = m_shadow;
        m_pend   = 0;
      end
      if (wr) begin
        m_shadow = (din < 2) ? 2 : din;
        m_pend   = 1;
      end
      m_count = restart ? 0 : m_count + 1;
      m_tick  = wrap;
      m_q     = (m_count >= m_active - m_active / 2);
    end
    sb.push_back('{cnt: m_count, tk: m_tick, qq: m_q, pend: m_pend});
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      vectors++;
      if (count !== W'(mon_e.cnt) || tick !== mon_e.tk || q !== mon_e.qq || div_pend !== mon_e.pend) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t: got count=%0d tick=%b q=%b pend=%b, want count=%0d tick=%b q=%b pend=%b",
                 $time, count, tick, q, div_pend, mon_e.cnt, mon_e.tk, mon_e.qq, mon_e.pend);
      end
    end
  end

  // Run enabled until a tick appears; n is the number of cycles taken (budget+1 if none).
  task automatic run_until_tick(input int budget, output int n);
    n = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      step(0, 1, 0, 0, 0);
      if (tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_until_count(input int unsigned target, input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget; i++) begin
      step(0, 1, 0, 0, 0);
      if (count === W'(target)) begin
        found = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 7, 0);
    vectors++;
    if (count !== '0 || tick !== 1'b0 || q !== 1'b0 || div_pend !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: count=%0d tick=%b q=%b pend=%b, want all zero", count, tick, q, div_pend);
    end
  endtask

  task automatic test_default_period();
    int n, hi, ticks;
    run_until_tick(3000, n);
    vectors++;
    if (n != 2048) begin
      miscompares++;
      $display("FAIL default_first_tick: %0d cycles, want 2048", n);
    end
    hi = 0; ticks = 0;
    for (int i = 0; i < 2048; i++) begin
      step(0, 1, 0, 0, 0);
      hi += int'(q);
      ticks += int'(tick);
    end
    vectors++;
    if (hi != 1024 || ticks != 1 || tick !== 1'b1) begin
      miscompares++;
      $display("FAIL default_period: high=%0d ticks=%0d end_tick=%b, want 1024 1 1", hi, ticks, tick);
    end
  endtask

  task automatic test_write_mid_period();
    bit found;
    int n;
    logic [4:0] pat;
    run_until_count(1000, 2100, found);
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL mid_wait: count 1000 not reached, count=%0d", count);
    end
    step(0, 1, 1, 5, 0);
    vectors++;
    if (div_pend !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pend: pend=%b, want 1", div_pend);
    end
    run_until_tick(2100, n);
    vectors++;
    if (n != 1047 || div_pend !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_apply: %0d cycles pend=%b, want 1047 0", n, div_pend);
    end
    pat[4] = q;
    for (int i = 3; i >= 0; i--) begin
      step(0, 1, 0, 0, 0);
      pat[i] = q;
    end
    vectors++;
    if (pat !== 5'b00011) begin
      miscompares++;
      $display("FAIL n5_pattern: q=%b, want 00011", pat);
    end
    step(0, 1, 0, 0, 0);
    vectors++;
    if (tick !== 1'b1) begin
      miscompares++;
      $display("FAIL n5_tick: tick=%b, want 1", tick);
    end
  endtask

  task automatic test_clamp();
    int n;
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    run_until_tick(10, n);
    vectors++;
    if (n > 5 || div_pend !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_apply: %0d cycles pend=%b, want <=5 0", n, div_pend);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 0);
      vectors++;
      if (q !== ((i % 2) == 0) || tick !== ((i % 2) == 1)) begin
        miscompares++;
        $display("FAIL clamp_n2 step %0d: q=%b tick=%b, want %b %b", i, q, tick, (i % 2) == 0, (i % 2) == 1);
      end
    end
  endtask

  task automatic test_write_at_wrap();
    bit found;
    int n;
    step(0, 1, 1, 8, 0);
    run_until_tick(10, n);
    step(0, 1, 1, 4, 0);
    run_until_count(7, 10, found);
    step(0, 1, 1, 6, 0);
    vectors++;
    if (!found || count !== '0 || tick !== 1'b1 || div_pend !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_write: found=%b count=%0d tick=%b pend=%b, want 1 0 1 1", found, count, tick, div_pend);
    end
    run_until_tick(10, n);
    vectors++;
    if (n != 4 || div_pend !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_next4: %0d cycles pend=%b, want 4 0", n, div_pend);
    end
    run_until_tick(10, n);
    vectors++;
    if (n != 6) begin
      miscompares++;
      $display("FAIL wrap_then6: %0d cycles, want 6", n);
    end
  endtask

  task automatic test_stop();
    bit found;
    int n;
    step(0, 1, 1, 10, 0);
    run_until_count(3, 10, found);
    step(0, 0, 0, 0, 0);
    vectors++;
    if (!found || count !== '0 || q !== 1'b0 || tick !== 1'b0 || div_pend !== 1'b0) begin
      miscompares++;
      $display("FAIL stop: found=%b count=%0d q=%b tick=%b pend=%b, want 1 0 0 0 0", found, count, q, tick, div_pend);
    end
    run_until_tick(20, n);
    vectors++;
    if (n != 10) begin
      miscompares++;
      $display("FAIL stop_resume: %0d cycles, want 10", n);
    end
    step(0, 0, 1, 3, 0);
    step(0, 0, 0, 0, 0);
    vectors++;
    if (div_pend !== 1'b0) begin
      miscompares++;
      $display("FAIL stopped_write: pend=%b, want 0", div_pend);
    end
    run_until_tick(20, n);
    vectors++;
    if (n != 3) begin
      miscompares++;
      $display("FAIL stopped_write_period: %0d cycles, want 3", n);
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    bit found;
    int n;
    step(0, 0, 1, 8, 0);
    step(0, 0, 0, 0, 0);
    run_until_count(6, 20, found);
    step(0, 1, 0, 0, 1);
    vectors++;
    if (!found || count !== '0 || tick !== 1'b0 || q !== 1'b0) begin
      miscompares++;
      $display("FAIL sync: found=%b count=%0d tick=%b q=%b, want 1 0 0 0", found, count, tick, q);
    end
    run_until_tick(20, n);
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL sync_period: %0d cycles, want 8", n);
    end
    run_until_count(7, 20, found);
    step(0, 1, 0, 0, 1);
    vectors++;
    if (!found || count !== '0 || tick !== 1'b0) begin
      miscompares++;
      $display("FAIL sync_at_wrap: found=%b count=%0d tick=%b, want 1 0 0", found, count, tick);
    end
  endtask
`endif

  task automatic test_rst_mid();
    int n;
    step(0, 1, 1, 9, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    vectors++;
    if (count !== '0 || tick !== 1'b0 || q !== 1'b0 || div_pend !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: count=%0d tick=%b q=%b pend=%b, want all zero", count, tick, q, div_pend);
    end
    run_until_tick(3000, n);
    vectors++;
    if (n != 2048) begin
      miscompares++;
      $display("FAIL rst_default: %0d cycles, want 2048", n);
    end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_write_mid_period();
    test_clamp();
    test_write_at_wrap();
    test_stop();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    test_rst_mid();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
